// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue stage: functional-unit classes and their count.
// The reservation station and dispatch stage import the same definitions.
package issue_scheduler_pkg;

  localparam int NUM_FU    = 3;
  localparam int FU_TYPE_W = 2;

  // Encoding carried in each reservation-station entry.
  typedef enum logic [FU_TYPE_W-1:0] {
    FU_ALU  = 2'b00,
    FU_LSU  = 2'b01,
    FU_BRU  = 2'b10,
    FU_NONE = 2'b11
  } fu_type_e;

  // Map an issue-port number (0=ALU, 1=LSU, 2=BRU) to its type code.
  // FU_NONE is never returned for a real port, so reserved entries never match.
  function automatic fu_type_e fu_type_of(input int unsigned fu);
    case (fu)
      0:       fu_type_of = FU_ALU;
      1:       fu_type_of = FU_LSU;
      2:       fu_type_of = FU_BRU;
      default: fu_type_of = FU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/issue_scheduler_age_select.sv
// Oldest-first selector for one functional unit.
// A binary tournament tree over (found, age, index) picks the requesting
// entry with the smallest ROB age; equal ages resolve to the lower RS index.
module issue_scheduler_age_select #(
  parameter int N     = 16,              // request count, power of two, >= 2
  parameter int ROB_W = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]       req,
  input  logic [N*ROB_W-1:0] rob_tags,
  input  logic [ROB_W-1:0]   rob_head,
  output logic               found,
  output logic [IDX_W-1:0]   win_idx
);

  // Heap-ordered tree: node 0 is the root, node k has children 2k+1 / 2k+2,
  // leaves sit at N-1 .. 2N-2 in RS-index order, so every left subtree holds
  // strictly lower indices than its right sibling.
  localparam int NODES = 2 * N - 1;

  logic             node_found [NODES];
  logic [ROB_W-1:0] node_age   [NODES];
  logic [IDX_W-1:0] node_idx   [NODES];

  // Leaves: age is distance from the ROB head, modulo the ROB size, which
  // stays correct when the ROB index wraps.
  for (genvar j = 0; j < N; j++) begin : g_leaf
    assign node_found[N-1+j] = req[j];
    assign node_age[N-1+j]   = rob_tags[j*ROB_W +: ROB_W] - rob_head;
    assign node_idx[N-1+j]   = IDX_W'(j);
  end

  // Internal nodes: the right child wins only if it is strictly older, or
  // the left child has no request; ties keep the lower index.
  for (genvar k = 0; k < N - 1; k++) begin : g_node
    logic take_r;
    assign take_r = node_found[2*k+2] &
                    (!node_found[2*k+1] || (node_age[2*k+2] < node_age[2*k+1]));
    assign node_found[k] = node_found[2*k+1] | node_found[2*k+2];
    assign node_age[k]   = take_r ? node_age[2*k+2] : node_age[2*k+1];
    assign node_idx[k]   = take_r ? node_idx[2*k+2] : node_idx[2*k+1];
  end

  assign found   = node_found[0];
  assign win_idx = node_idx[0];

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: per FU class, grants the oldest ready RS entry, frees it
// in the RS via rs_grant, and holds it in an issue register that drains to
// the FU under a valid/ready handshake.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = 16,
  parameter int ROB_WIDTH      = 5,
  parameter int RS_IDX_W       = $clog2(NUM_RS_ENTRIES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [ROB_WIDTH-1:0]               rob_head,
  input  logic [NUM_RS_ENTRIES-1:0]          rs_valid,
  input  logic [NUM_RS_ENTRIES-1:0]          rs_ready,
  input  logic [FU_TYPE_W*NUM_RS_ENTRIES-1:0] rs_fu_type,
  input  logic [ROB_WIDTH*NUM_RS_ENTRIES-1:0] rs_rob_idx,
  output logic [NUM_RS_ENTRIES-1:0]          rs_grant,
  input  logic [NUM_FU-1:0]                  fu_ready,
  output logic [NUM_FU-1:0]                  issue_valid,
  output logic [NUM_FU*RS_IDX_W-1:0]         issue_rs_idx,
  output logic [NUM_FU*ROB_WIDTH-1:0]        issue_rob_idx
);

  logic [NUM_RS_ENTRIES-1:0] fu_req [NUM_FU];
  logic [NUM_FU-1:0]         fu_found;
  logic [RS_IDX_W-1:0]       win_idx [NUM_FU];
  logic [NUM_FU-1:0]         slot_free;
  logic [NUM_FU-1:0]         fu_grant;

  logic [NUM_FU-1:0]         valid_q;
  logic [RS_IDX_W-1:0]       rs_idx_q  [NUM_FU];
  logic [ROB_WIDTH-1:0]      rob_idx_q [NUM_FU];

  // Candidate vectors: occupied, operands ready, and of this FU's class.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
        fu_req[f][i] = rs_valid[i] & rs_ready[i] &
                       (fu_type_e'(rs_fu_type[FU_TYPE_W*i +: FU_TYPE_W]) == fu_type_of(f));
      end
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
    issue_scheduler_age_select #(
      .N     (NUM_RS_ENTRIES),
      .ROB_W (ROB_WIDTH),
      .IDX_W (RS_IDX_W)
    ) u_age_select (
      .req      (fu_req[f]),
      .rob_tags (rs_rob_idx),
      .rob_head (rob_head),
      .found    (fu_found[f]),
      .win_idx  (win_idx[f])
    );
  end

  // An issue slot accepts a new op when empty or draining this cycle; flush
  // and reset suppress every grant so the RS keeps its entries.
  always_comb begin
    slot_free = ~valid_q | fu_ready;
    fu_grant  = fu_found & slot_free & {NUM_FU{~flush & rst}};
  end

  // Expand each FU's winning index into the one-hot-per-FU grant mask.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps every bit
    // driven on every path, so no latch is inferred.
    rs_grant = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (fu_grant[f]) rs_grant[win_idx[f]] = 1'b1;
    end
  end

  // Issue registers: reset and flush dominate, then load on grant, then
  // drain on fu_ready; otherwise hold so fields stay stable under backpressure.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      valid_q <= '0;
      for (int f = 0; f < NUM_FU; f++) begin
        rs_idx_q[f]  <= '0;
        rob_idx_q[f] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (fu_grant[f]) begin
          valid_q[f]   <= 1'b1;
          rs_idx_q[f]  <= win_idx[f];
          rob_idx_q[f] <= rs_rob_idx[ROB_WIDTH*win_idx[f] +: ROB_WIDTH];
        end else if (fu_ready[f]) begin
          valid_q[f] <= 1'b0;
        end
      end
    end
  end

  // Flatten the issue registers onto the output ports.
  always_comb begin
    issue_valid   = valid_q;
    issue_rs_idx  = '0;
    issue_rob_idx = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      issue_rs_idx[f*RS_IDX_W +: RS_IDX_W]    = rs_idx_q[f];
      issue_rob_idx[f*ROB_WIDTH +: ROB_WIDTH] = rob_idx_q[f];
    end
  end

endmodule
